// File: rtl/led_bank_pkg.sv
// led_bank_pkg: shared types and helpers for the multi-channel LED driver.
//   mode_e    - per-channel operating mode (off, on, blink, breathe)
//   breathe_e - breathe ramp direction
//   ch_width  - width of the channel-select field for a given channel count
package led_bank_pkg;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic {
    StUp   = 1'b0,
    StDown = 1'b1
  } breathe_e;

  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_bank_if.sv
// led_bank_if: single-port channel write bus.
//   wr_en   - write strobe, one write per cycle, always accepted
//   wr_ch   - target channel (values >= CHANNELS are ignored by the slave)
//   wr_mode - mode to load (led_bank_pkg::mode_e encoding)
//   wr_duty - PWM brightness to load
// Modports: master drives the bus, slave (led_bank) receives it.
interface led_bank_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned PWM_BITS = 8
);

  localparam int unsigned ChW = led_bank_pkg::ch_width(CHANNELS);

  logic                wr_en;
  logic [ChW-1:0]      wr_ch;
  logic [1:0]          wr_mode;
  logic [PWM_BITS-1:0] wr_duty;

  modport master (output wr_en, output wr_ch, output wr_mode, output wr_duty);
  modport slave  (input  wr_en, input  wr_ch, input  wr_mode, input  wr_duty);

endinterface

// File: rtl/led_bank_channel.sv
// led_bank_channel: one LED channel.
//   clk, rst  - system clock, asynchronous active-high reset
//   wr_sel    - write strobe already decoded for this channel
//   wr_mode   - mode to load into the shadow register
//   wr_duty   - duty to load into the shadow register
//   frame     - PWM frame boundary pulse (commit point)
//   pwm_cnt   - shared PWM counter
//   led       - registered active-low LED drive
// Optional feature: LED_BANK_BREATHE_EN builds the breathe ramp; otherwise
// mode 3 behaves as ON.
module led_bank_channel
  import led_bank_pkg::*;
#(
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_sel,
  input  logic [1:0]          wr_mode,
  input  logic [PWM_BITS-1:0] wr_duty,
  input  logic                frame,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  output logic                led
);

  localparam int unsigned BlinkW = $clog2(BLINK_FRAMES + 1);

  mode_e               shadow_mode_q, act_mode_q;
  logic [PWM_BITS-1:0] shadow_duty_q, act_duty_q;
  logic                pending_q;
  logic [BlinkW-1:0]   blink_cnt_q;
  logic                blink_dark_q;
  logic                led_q;
  logic [PWM_BITS-1:0] d_eff;
  logic                lit;

  // A write on a frame cycle lands after the commit, so it waits one frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_mode_q <= MODE_OFF;
      shadow_duty_q <= '0;
      pending_q     <= 1'b0;
      act_mode_q    <= MODE_OFF;
      act_duty_q    <= '0;
      blink_cnt_q   <= '0;
      blink_dark_q  <= 1'b0;
      led_q         <= 1'b1;
    end else begin
      if (frame) begin
        if (pending_q) begin
          act_mode_q   <= shadow_mode_q;
          act_duty_q   <= shadow_duty_q;
          pending_q    <= 1'b0;
          blink_cnt_q  <= '0;
          blink_dark_q <= 1'b0;
        end else if (blink_cnt_q == BlinkW'(BLINK_FRAMES - 1)) begin
          blink_cnt_q  <= '0;
          blink_dark_q <= ~blink_dark_q;
        end else begin
          blink_cnt_q  <= blink_cnt_q + BlinkW'(1);
        end
      end
      if (wr_sel) begin
        shadow_mode_q <= mode_e'(wr_mode);
        shadow_duty_q <= wr_duty;
        pending_q     <= 1'b1;
      end
      led_q <= ~lit;
    end
  end

`ifdef LED_BANK_BREATHE_EN
  breathe_e            bstate_q;
  logic [PWM_BITS-1:0] level_q;
  logic [PWM_BITS-1:0] level_up;
  logic [PWM_BITS-1:0] level_dn;

  assign level_up = level_q + PWM_BITS'(1);
  assign level_dn = level_q - PWM_BITS'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bstate_q <= StUp;
      level_q  <= '0;
    end else if (frame) begin
      if (pending_q) begin
        bstate_q <= StUp;
        level_q  <= '0;
      end else begin
        unique case (bstate_q)
          StUp: begin
            // duty 0 parks the ramp at 0
            if (act_duty_q != '0) begin
              level_q <= level_up;
              if (level_up == act_duty_q) bstate_q <= StDown;
            end
          end
          StDown: begin
            level_q <= level_dn;
            if (level_dn == '0) bstate_q <= StUp;
          end
        endcase
      end
    end
  end
`endif

  always_comb begin
    d_eff = '0;
    unique case (act_mode_q)
      MODE_OFF:     d_eff = '0;
      MODE_ON:      d_eff = act_duty_q;
      MODE_BLINK:   d_eff = blink_dark_q ? '0 : act_duty_q;
`ifdef LED_BANK_BREATHE_EN
      MODE_BREATHE: d_eff = level_q;
`else
      MODE_BREATHE: d_eff = act_duty_q;
`endif
    endcase
  end

  // All-ones duty would otherwise miss the last count of the frame.
  assign lit = (d_eff == '1) || (pwm_cnt < d_eff);
  assign led = led_q;

endmodule

// File: rtl/led_bank.sv
// led_bank: multi-channel active-low LED driver with shared PWM timebase.
//   clk   - system clock
//   rst   - asynchronous active-high reset
//   bus   - led_bank_if.slave write port (wr_en, wr_ch, wr_mode, wr_duty)
//   led   - CHANNELS active-low LED outputs (1 = dark)
//   frame - one-cycle pulse on the PWM counter wrap cycle
// Optional feature macro: LED_BANK_BREATHE_EN (breathe mode in each channel).
module led_bank
  import led_bank_pkg::*;
#(
  parameter int unsigned CHANNELS     = 4,
  parameter int unsigned PWM_BITS     = 8,
  parameter int unsigned PRESCALE     = 98,
  parameter int unsigned BLINK_FRAMES = 250
) (
  input  logic                clk,
  input  logic                rst,
  led_bank_if.slave           bus,
  output logic [CHANNELS-1:0] led,
  output logic                frame
);

  localparam int unsigned ChW = ch_width(CHANNELS);
  localparam int unsigned PsW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PsW-1:0]      presc_q;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic                tick;

  assign tick  = (presc_q == PsW'(PRESCALE - 1));
  assign frame = tick && (pwm_cnt_q == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PsW'(1);
      if (tick) pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic wr_sel;
    // Out-of-range channel numbers never match any index.
    assign wr_sel = bus.wr_en && (bus.wr_ch == ChW'(i));

    led_bank_channel #(
      .PWM_BITS     (PWM_BITS),
      .BLINK_FRAMES (BLINK_FRAMES)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .wr_sel  (wr_sel),
      .wr_mode (bus.wr_mode),
      .wr_duty (bus.wr_duty),
      .frame   (frame),
      .pwm_cnt (pwm_cnt_q),
      .led     (led[i])
    );
  end

endmodule

// File: tb/tb_led_bank.sv
// tb_led_bank: self-checking bench for led_bank (CHANNELS=4, PWM_BITS=4,
// PRESCALE=2, BLINK_FRAMES=2). Directed script from the test plan, then
// random writes, then an asynchronous mid-frame reset. Expected outputs come
// from a frame-level reference model built on elapsed time since reset.
module tb_led_bank;

  localparam int CH    = 4;
  localparam int PB    = 4;
  localparam int PS    = 2;
  localparam int BF    = 2;
  localparam int FRAME = PS * (1 << PB);
  localparam int MAXD  = (1 << PB) - 1;

  logic          clk;
  logic          rst;
  logic [CH-1:0] led;
  logic          frame;

  led_bank_if #(.CHANNELS(CH), .PWM_BITS(PB)) bus ();

  led_bank #(
    .CHANNELS     (CH),
    .PWM_BITS     (PB),
    .PRESCALE     (PS),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .led   (led),
    .frame (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;  // cycles since reset release

  // Reference model state
  int            sh_mode[CH], sh_duty[CH], act_mode[CH], act_duty[CH], nfr[CH];
  bit            pend[CH];
  logic [CH-1:0] exp_led;

  typedef struct {
    int t;
    int ch;
    int mode;
    int duty;
  } wr_t;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  function automatic bit is_frame(input int tc);
    return (tc % FRAME) == FRAME - 1;
  endfunction

  function automatic int pwm_at(input int tc);
    return (tc / PS) % (1 << PB);
  endfunction

  // Effective duty from mode and number of frames since commit.
  function automatic int deff(input int c);
    int d, p;
    d = act_duty[c];
    case (act_mode[c])
      0: return 0;
      1: return d;
      2: return ((nfr[c] / BF) % 2 == 0) ? d : 0;
      default: begin
`ifdef LED_BANK_BREATHE_EN
        if (d == 0) return 0;
        p = nfr[c] % (2 * d);
        return (p <= d) ? p : 2 * d - p;
`else
        p = 0;
        return d + p;
`endif
      end
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      sh_mode[c] = 0; sh_duty[c] = 0; act_mode[c] = 0; act_duty[c] = 0;
      nfr[c] = 0; pend[c] = 1'b0;
    end
    exp_led = '1;
    t = 0;
  endtask

  // Called just after a negedge: drive inputs, check, advance one cycle.
  task automatic run_cycle(input bit we, input int ch, input int mode, input int duty);
    logic [CH-1:0] nxt;
    int d;
    bus.wr_en   = we;
    bus.wr_ch   = 2'(ch);
    bus.wr_mode = 2'(mode);
    bus.wr_duty = 4'(duty);
    #1;
    check_val("frame", 32'(frame), 32'(is_frame(t)));
    check_val("led", 32'(led), 32'(exp_led));
    for (int c = 0; c < CH; c++) begin
      d = deff(c);
      nxt[c] = !((d == MAXD) || (pwm_at(t) < d));
    end
    if (is_frame(t)) begin
      for (int c = 0; c < CH; c++) begin
        if (pend[c]) begin
          act_mode[c] = sh_mode[c]; act_duty[c] = sh_duty[c];
          nfr[c] = 0; pend[c] = 1'b0;
        end else begin
          nfr[c]++;
        end
      end
    end
    if (we && ch < CH) begin
      sh_mode[ch] = mode; sh_duty[ch] = duty; pend[ch] = 1'b1;
    end
    @(posedge clk);
    exp_led = nxt;
    t++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b0, 0, 0, 0);
  endtask

  // Holds rst for a few cycles (rst may already be high) and releases it.
  task automatic do_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_val("rst_led", 32'(led), 32'hF);
    check_val("rst_frame", 32'(frame), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  wr_t script[6] = '{
    '{10, 0, 1, 4},   // ch0 ON duty 4 mid-frame
    '{12, 1, 2, 15},  // ch1 BLINK full brightness
    '{14, 2, 1, 3},   // ch2 ON 3 ...
    '{16, 2, 1, 9},   // ... overwritten by ON 9 before the frame
    '{18, 3, 3, 3},   // ch3 BREATHE duty 3
    '{63, 2, 1, 5}    // frame-cycle write, commits one frame later
  };

  initial begin
    bit hit;
    int sc, sm, sd;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_mode = '0; bus.wr_duty = '0;
    do_reset();

    // Directed script
    for (int i = 0; i < 12 * FRAME; i++) begin
      hit = 1'b0; sc = 0; sm = 0; sd = 0;
      foreach (script[k]) begin
        if (script[k].t == t) begin
          hit = 1'b1; sc = script[k].ch; sm = script[k].mode; sd = script[k].duty;
        end
      end
      run_cycle(hit, sc, sm, sd);
    end

    // Random writes
    for (int i = 0; i < 40 * FRAME; i++) begin
      run_cycle(($urandom_range(0, 7) == 0), int'($urandom_range(0, CH - 1)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, MAXD)));
    end

    // All channels fully lit, then asynchronous reset mid-frame
    for (int c = 0; c < CH; c++) run_cycle(1'b1, c, 1, MAXD);
    idle(FRAME + 10);
    check_val("all_lit", 32'(led), 32'h0);
    #1;
    rst = 1'b1;
    #1;
    check_val("async_rst_led", 32'(led), 32'hF);
    do_reset();

    // Channels stay OFF until rewritten, then resume normally
    idle(3 * FRAME);
    run_cycle(1'b1, 0, 1, 4);
    run_cycle(1'b1, 1, 2, 7);
    idle(6 * FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
